// File: rtl/en_ext_mem_port.sv
// External-memory port for the ElectronNest top: boot token streamer, fixed-latency
// load server and store committer in front of a simple-dual-port read-first BRAM.

package pkg_en;
  localparam int WIDTH_DATA   = 32;
  localparam int WIDTH_EXADDR = 16;

  typedef struct packed {
    logic                    v;
    logic                    a;
    logic                    c;
    logic                    r;
    logic [WIDTH_EXADDR-1:0] i;
    logic [WIDTH_DATA-1:0]   d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;
endpackage

module en_ext_mem_port #(
  parameter int WIDTH_DATA   = pkg_en::WIDTH_DATA,
  parameter int WIDTH_EXADDR = pkg_en::WIDTH_EXADDR,
  parameter int NUM_PAD      = 3,
  parameter int NUM_PROG     = 5,
  parameter int USE_INDEX    = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    I_Boot,
  input  logic                    I_Ld_Req,
  input  logic [WIDTH_EXADDR-1:0] I_Ld_Addr,
  output pkg_en::FTk_t            O_Ld_FTk,
  input  pkg_en::BTk_t            I_Ld_BTk,
  input  logic                    I_St_Req,
  input  logic [WIDTH_EXADDR-1:0] I_St_Addr,
  input  pkg_en::FTk_t            I_St_FTk,
  output pkg_en::BTk_t            O_St_BTk,
  output logic                    O_Mem_Rd_En,
  output logic [WIDTH_EXADDR-1:0] O_Mem_Rd_Addr,
  input  logic [WIDTH_DATA-1:0]   I_Mem_Rd_Data,
  output logic                    O_Mem_Wr_En,
  output logic [WIDTH_EXADDR-1:0] O_Mem_Wr_Addr,
  output logic [WIDTH_DATA-1:0]   O_Mem_Wr_Data,
  output logic                    O_Boot_Busy
);

  localparam int CNT_MAX = (NUM_PAD > NUM_PROG) ? NUM_PAD : NUM_PROG;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PAD_LAST  = CNT_W'(NUM_PAD - 1);
  localparam logic [CNT_W-1:0] PROG_LAST = CNT_W'(NUM_PROG - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAD,
    ST_PROG,
    ST_RUN
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    ld_vld_q, ld_vld_d;
  logic [WIDTH_EXADDR-1:0] ld_idx_q, ld_idx_d;
  logic [WIDTH_DATA-1:0]   hold_q, hold_d;

  logic                    ld_go;
  logic                    st_try;
  logic                    st_acc;
  pkg_en::FTk_t            ld_tok;
  pkg_en::BTk_t            st_btk;

  // A load arriving together with a re-boot request is dropped: the next cycle is a PAD token.
  assign ld_go  = (state_q == ST_RUN) & I_Ld_Req & ~I_Boot;
  assign st_try = I_St_Req & I_St_FTk.v;
  assign st_acc = st_try & (state_q == ST_RUN);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (I_Boot) begin
          state_d = ST_PAD;
          cnt_d   = '0;
        end
      end
      ST_PAD: begin
        if (cnt_q == PAD_LAST) begin
          state_d = ST_PROG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PROG: begin
        if (cnt_q == PROG_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (I_Boot) begin
          state_d = ST_PAD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy_d   = (state_d == ST_PAD) || (state_d == ST_PROG);
    ld_vld_d = ld_go;
    ld_idx_d = ld_go ? I_Ld_Addr : ld_idx_q;
    hold_d   = hold_q;
    if ((state_q == ST_PROG) || ((state_q == ST_RUN) && ld_vld_q)) begin
      hold_d = I_Mem_Rd_Data;
    end
  end

  // Read port: boot prefetch runs one cycle ahead of the PROG token that consumes it.
  always_comb begin
    O_Mem_Rd_En   = 1'b0;
    O_Mem_Rd_Addr = '0;
    if ((state_q == ST_PAD) && (cnt_q == PAD_LAST)) begin
      O_Mem_Rd_En   = 1'b1;
      O_Mem_Rd_Addr = '0;
    end else if ((state_q == ST_PROG) && (cnt_q != PROG_LAST)) begin
      O_Mem_Rd_En   = 1'b1;
      O_Mem_Rd_Addr = WIDTH_EXADDR'(cnt_q) + 1'b1;
    end else if (ld_go) begin
      O_Mem_Rd_En   = 1'b1;
      O_Mem_Rd_Addr = I_Ld_Addr;
    end
  end

  always_comb begin
    ld_tok = '0;
    unique case (state_q)
      ST_PAD: begin
        ld_tok.v = 1'b1;
        ld_tok.a = (cnt_q == '0);
      end
      ST_PROG: begin
        ld_tok.v = 1'b1;
        ld_tok.d = I_Mem_Rd_Data;
      end
      ST_RUN: begin
        ld_tok.v = ld_vld_q;
        ld_tok.d = ld_vld_q ? I_Mem_Rd_Data : hold_q;
        ld_tok.i = (USE_INDEX != 0) ? ld_idx_q : '0;
      end
      default: ld_tok = '0;
    endcase
  end

  // The nack is the only output not already forced low by the IDLE state, so gate it with reset.
  always_comb begin
    st_btk   = '0;
    st_btk.n = st_try & (state_q != ST_RUN) & ~reset;
  end

  assign O_Ld_FTk      = ld_tok;
  assign O_St_BTk      = st_btk;
  assign O_Mem_Wr_En   = st_acc;
  assign O_Mem_Wr_Addr = st_acc ? I_St_Addr : '0;
  assign O_Mem_Wr_Data = st_acc ? I_St_FTk.d : '0;
  assign O_Boot_Busy   = busy_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      ld_vld_q <= 1'b0;
      ld_idx_q <= '0;
      hold_q   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ld_vld_q <= ld_vld_d;
      ld_idx_q <= ld_idx_d;
      hold_q   <= hold_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{I_Ld_BTk, I_St_FTk.a, I_St_FTk.c, I_St_FTk.r, I_St_FTk.i};

endmodule
